matrix_loader: RTL and testbench



---
 rtl/matrix_loader.sv | 120 ++++++++++++
 tb/tb_matrix_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Packs an 8-bit element stream (A row-major, then B row-major) into flat a/b vectors.
// One element per cycle. mat_valid rises 1 cycle after the last B element. in_ready is low while a frame is held.
module matrix_loader #(
  parameter int A_ROW = 2,
  parameter int A_COL = 2,
  parameter int B_ROW = 2,
  parameter int B_COL = 2,
  localparam int MATRIX_A_LEN = A_ROW * A_COL * 8,
  localparam int MATRIX_B_LEN = B_ROW * B_COL * 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  output logic [MATRIX_A_LEN-1:0] a,
  output logic [MATRIX_B_LEN-1:0] b,
  output logic                    mat_valid,
  input  logic                    mat_ack,
  output logic                    dim_err,
  output logic [7:0]              frame_cnt
);

  localparam int NA = A_ROW * A_COL;
  localparam int NB = B_ROW * B_COL;
  localparam int NMAX = (NA > NB) ? NA : NB;
  localparam int IDX_W = $clog2(NMAX + 1);
  localparam logic DIM_ERR = (A_COL != B_ROW);

  typedef enum logic [1:0] {S_LOAD_A, S_LOAD_B, S_FULL} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [MATRIX_A_LEN-1:0] a_q, a_d;
  logic [MATRIX_B_LEN-1:0] b_q, b_d;
  logic                    mat_valid_q, mat_valid_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;
  logic                    xfer;

  assign dim_err   = DIM_ERR;
  assign in_ready  = !rst && !DIM_ERR && (state_q != S_FULL);
  assign xfer      = in_valid && in_ready;
  assign a         = a_q;
  assign b         = b_q;
  assign mat_valid = mat_valid_q;
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    mat_valid_d = mat_valid_q;
    frame_cnt_d = frame_cnt_q;
    if (flush) begin
      // Abort keeps the packed data; only the frame position is rewound.
      state_d     = S_LOAD_A;
      idx_d       = '0;
      mat_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD_A: begin
          if (xfer) begin
            for (int i = 0; i < NA; i++) begin
              if (idx_q == IDX_W'(i)) a_d[8*(NA-1-i) +: 8] = in_data;
            end
            if (idx_q == IDX_W'(NA - 1)) begin
              state_d = S_LOAD_B;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        S_LOAD_B: begin
          if (xfer) begin
            for (int i = 0; i < NB; i++) begin
              if (idx_q == IDX_W'(i)) b_d[8*(NB-1-i) +: 8] = in_data;
            end
            if (idx_q == IDX_W'(NB - 1)) begin
              state_d     = S_FULL;
              idx_d       = '0;
              mat_valid_d = 1'b1;
              frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        S_FULL: begin
          if (mat_ack) begin
            state_d     = S_LOAD_A;
            mat_valid_d = 1'b0;
          end
        end
        default: state_d = S_LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD_A;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mat_valid_q <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mat_valid_q <= mat_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: 2x2 default instance with scoreboard, plus non-square and mismatched instances.
module tb_matrix_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, mat_ack;
  logic [7:0] in_data;
  logic in_ready, mat_valid, dim_err;
  logic [31:0] a, b;
  logic [7:0] frame_cnt;

  matrix_loader dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .a(a), .b(b), .mat_valid(mat_valid), .mat_ack(mat_ack),
    .dim_err(dim_err), .frame_cnt(frame_cnt)
  );

  logic ns_valid, ns_ready, ns_mat_valid, ns_dim_err;
  logic [7:0] ns_data, ns_cnt;
  logic [47:0] ns_a;
  logic [23:0] ns_b;
  matrix_loader #(.A_ROW(2), .A_COL(3), .B_ROW(3), .B_COL(1)) dut_ns (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(ns_valid), .in_ready(ns_ready),
    .in_data(ns_data), .a(ns_a), .b(ns_b), .mat_valid(ns_mat_valid), .mat_ack(1'b0),
    .dim_err(ns_dim_err), .frame_cnt(ns_cnt)
  );

  logic em_valid = 1'b1;
  logic em_ready, em_mat_valid, em_dim_err;
  logic [7:0] em_data, em_cnt;
  logic [47:0] em_a;
  logic [31:0] em_b;
  matrix_loader #(.A_ROW(2), .A_COL(3), .B_ROW(2), .B_COL(2)) dut_em (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(em_valid), .in_ready(em_ready),
    .in_data(em_data), .a(em_a), .b(em_b), .mat_valid(em_mat_valid), .mat_ack(1'b1),
    .dim_err(em_dim_err), .frame_cnt(em_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: element arrays, frame position and completed-frame count.
  logic [7:0] ea[4];
  logic [7:0] eb[4];
  int pos = 0;
  logic [7:0] cnt = 8'd0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  cnt;
  } frame_t;
  frame_t exp_q[$];

  function automatic logic [31:0] pack_a();
    logic [31:0] v = 32'd0;
    for (int i = 0; i < 4; i++) v = (v << 8) | 32'(ea[i]);
    return v;
  endfunction

  function automatic logic [31:0] pack_b();
    logic [31:0] v = 32'd0;
    for (int i = 0; i < 4; i++) v = (v << 8) | 32'(eb[i]);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin ea[i] = 8'd0; eb[i] = 8'd0; end
    pos = 0;
    cnt = 8'd0;
    exp_q.delete();
  endtask

  // Monitor: each rising mat_valid must match the next expected frame.
  logic mv_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && mat_valid && !mv_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got mat_valid=1 expected no frame pending");
      end else begin
        frame_t f;
        f = exp_q.pop_front();
        chk("frame_a", 64'(a), 64'(f.a));
        chk("frame_b", 64'(b), 64'(f.b));
        chk("frame_cnt", 64'(frame_cnt), 64'(f.cnt));
      end
    end
    mv_prev = mat_valid;
  end

  // The mismatched instance must never accept or present anything.
  logic em_seen_ready = 1'b0;
  logic em_seen_valid = 1'b0;
  always @(negedge clk) begin
    em_data = 8'($urandom);
    if (em_ready) em_seen_ready = 1'b1;
    if (em_mat_valid) em_seen_valid = 1'b1;
  end

  // All tasks start and end just after a falling edge.
  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    flush    = 1'b0;
    mat_ack  = 1'b0;
    #1;
    chk("in_ready_load", 64'(in_ready), 64'd1);
    if (pos < 4) ea[pos] = d;
    else eb[pos-4] = d;
    pos++;
    if (pos == 8) begin
      frame_t f;
      pos = 0;
      cnt = cnt + 8'd1;
      f.a = pack_a();
      f.b = pack_b();
      f.cnt = cnt;
      exp_q.push_back(f);
      @(negedge clk);
      chk("mat_valid_latency", 64'(mat_valid), 64'd1);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic consume(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      #1;
      chk("in_ready_full", 64'(in_ready), 64'd0);
      chk("mat_valid_hold", 64'(mat_valid), 64'd1);
      @(negedge clk);
    end
    mat_ack  = 1'b1;
    in_valid = 1'($urandom);
    in_data  = 8'($urandom);
    @(negedge clk);
    mat_ack  = 1'b0;
    in_valid = 1'b0;
    chk("ack_clears", 64'(mat_valid), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] gv[8];
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mat_ack = 1'b0; in_data = 8'd0;
    ns_valid = 1'b0; ns_data = 8'd0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_a", 64'(a), 64'd0);
    chk("rst_b", 64'(b), 64'd0);
    chk("rst_mat_valid", 64'(mat_valid), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("dim_err_ok", 64'(dim_err), 64'd0);
    chk("dim_err_mismatch", 64'(em_dim_err), 64'd1);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Non-square 2x3 * 3x1 frame.
    for (int i = 0; i < 9; i++) begin
      ns_valid = 1'b1;
      ns_data  = 8'(i + 1);
      #1;
      chk("ns_in_ready", 64'(ns_ready), 64'd1);
      @(negedge clk);
    end
    ns_valid = 1'b0;
    chk("ns_mat_valid", 64'(ns_mat_valid), 64'd1);
    chk("ns_a", 64'(ns_a), 64'h010203040506);
    chk("ns_b", 64'(ns_b), 64'h070809);
    chk("ns_dim_err", 64'(ns_dim_err), 64'd0);

    // Back-to-back 01..08.
    for (int i = 0; i < 8; i++) send(8'(i + 1));
    chk("t1_a", 64'(a), 64'h01020304);
    chk("t1_b", 64'(b), 64'h05060708);
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);

    // Backpressure: 0xAA offered while full, then accepted as A[0][0] after ack.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_a", 64'(a), 64'h01020304);
      chk("bp_b", 64'(b), 64'h05060708);
      @(negedge clk);
    end
    mat_ack = 1'b1;
    @(negedge clk);
    mat_ack = 1'b0;
    chk("bp_ack_clears", 64'(mat_valid), 64'd0);
    send(8'hAA);
    for (int i = 0; i < 7; i++) send(8'($urandom));
    chk("bp_a00", 64'(a[31:24]), 64'hAA);
    consume(2);

    // Gapped frame with negative values.
    gv[0] = 8'hFF; gv[1] = 8'h80; gv[2] = 8'h11; gv[3] = 8'h7F;
    gv[4] = 8'h80; gv[5] = 8'hFF; gv[6] = 8'h01; gv[7] = 8'hFE;
    for (int i = 0; i < 8; i++) begin
      send(gv[i]);
      if (i < 7) idle();
    end
    chk("gap_a", 64'(a), 64'hFF80117F);
    chk("gap_b", 64'(b), 64'h80FF01FE);
    consume(0);

    // Flush after A plus two B elements; the offered element is discarded.
    for (int i = 0; i < 6; i++) send(8'($urandom));
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    pos = 0;
    chk("flush_mat_valid", 64'(mat_valid), 64'd0);
    chk("flush_a_kept", 64'(a), 64'(pack_a()));
    chk("flush_b_kept", 64'(b), 64'(pack_b()));
    chk("flush_cnt_kept", 64'(frame_cnt), 64'(cnt));
    for (int i = 0; i < 8; i++) send(8'($urandom));
    consume(1);

    // Reset mid-frame with flush and mat_ack also high.
    for (int i = 0; i < 3; i++) send(8'($urandom));
    rst = 1'b1; flush = 1'b1; mat_ack = 1'b1; in_valid = 1'b1;
    #1;
    chk("in_ready_in_rst", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("rst2_a", 64'(a), 64'd0);
    chk("rst2_b", 64'(b), 64'd0);
    chk("rst2_mat_valid", 64'(mat_valid), 64'd0);
    chk("rst2_frame_cnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0; flush = 1'b0; mat_ack = 1'b0; in_valid = 1'b0;
    model_clear();
    #1;
    chk("in_ready_after_rst2", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Random frames with gaps and delayed acks; frame_cnt wraps past 255.
    for (int f = 0; f < 260; f++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 2) == 0) idle();
        send(8'($urandom));
      end
      consume(int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    chk("frames_pending", 64'(exp_q.size()), 64'd0);
    chk("em_never_ready", 64'(em_seen_ready), 64'd0);
    chk("em_never_valid", 64'(em_seen_valid), 64'd0);
    chk("em_dim_err_end", 64'(em_dim_err), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
